// File: rtl/pcie_tx_arbiter.sv
// Packet-atomic TLP arbiter: NUM_CH AXI-Stream sources onto one PCIe TX port.
// Define PCIE_TX_ARBITER_STATS_EN to add the tlp_cnt / cancel_cnt statistics ports.
module pcie_tx_arbiter #(
    parameter int NUM_CH       = 4,
    parameter int C_DATA_WIDTH = 64,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
    parameter int ARB_MODE     = 1,
    parameter int CH_W         = $clog2(NUM_CH)
) (
    input  logic                           pcie_clk,
    input  logic                           sys_rst_n,
    input  logic [NUM_CH-1:0]              ch_req,
    output logic [NUM_CH-1:0]              ch_ack,
    input  logic [NUM_CH-1:0]              ch_tvalid,
    output logic [NUM_CH-1:0]              ch_tready,
    input  logic [NUM_CH-1:0]              ch_tlast,
    input  logic [NUM_CH*KEEP_WIDTH-1:0]   ch_tkeep,
    input  logic [NUM_CH*C_DATA_WIDTH-1:0] ch_tdata,
    input  logic [NUM_CH*4-1:0]            ch_tuser,
    input  logic                           tx_tready,
    output logic                           tx_tvalid,
    output logic                           tx_tlast,
    output logic [KEEP_WIDTH-1:0]          tx_tkeep,
    output logic [C_DATA_WIDTH-1:0]        tx_tdata,
    output logic [3:0]                     tx_tuser,
    output logic [CH_W-1:0]                grant_idx,
    output logic                           busy
`ifdef PCIE_TX_ARBITER_STATS_EN
    ,
    output logic [NUM_CH*32-1:0]           tlp_cnt,
    output logic [15:0]                    cancel_cnt
`endif
);

    typedef enum logic {ST_IDLE, ST_GRANT} state_e;

    state_e          state_q, state_d;
    logic [CH_W-1:0] grant_q, grant_d;
    logic [CH_W-1:0] ptr_q, ptr_d;
    logic            started_q, started_d;

    logic [CH_W-1:0] winner, win_hi, win_lo;
    logic            hit_hi, hit_lo;
    logic            sel_req, accept, done, cancel;

    // Round-robin: first requester above the pointer wins, otherwise wrap to the lowest.
    // Fixed priority funnels every requester into the "above" set so the lowest index wins.
    always_comb begin
        win_hi = '0;
        win_lo = '0;
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_req[i]) begin
                if (ARB_MODE == 0 || CH_W'(i) > ptr_q) begin
                    if (!hit_hi) begin
                        win_hi = CH_W'(i);
                        hit_hi = 1'b1;
                    end
                end else if (!hit_lo) begin
                    win_lo = CH_W'(i);
                    hit_lo = 1'b1;
                end
            end
        end
        winner = hit_hi ? win_hi : win_lo;
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        started_d = started_q;
        tx_tvalid = 1'b0;
        tx_tlast  = 1'b0;
        tx_tkeep  = '0;
        tx_tdata  = '0;
        tx_tuser  = '0;
        ch_tready = '0;
        sel_req   = 1'b0;
        accept    = 1'b0;
        done      = 1'b0;
        cancel    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|ch_req) begin
                    state_d   = ST_GRANT;
                    grant_d   = winner;
                    started_d = 1'b0;
                    if (ARB_MODE != 0) ptr_d = winner;
                end
            end
            ST_GRANT: begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (grant_q == CH_W'(i)) begin
                        tx_tvalid    = ch_tvalid[i];
                        tx_tlast     = ch_tlast[i];
                        tx_tkeep     = ch_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                        tx_tdata     = ch_tdata[i*C_DATA_WIDTH +: C_DATA_WIDTH];
                        tx_tuser     = ch_tuser[i*4 +: 4];
                        sel_req      = ch_req[i];
                        ch_tready[i] = tx_tready;
                    end
                end
                accept = tx_tvalid & tx_tready;
                if (accept && tx_tlast) begin
                    done      = 1'b1;
                    state_d   = ST_IDLE;
                    started_d = 1'b0;
                end else if (!sel_req && !started_q && !tx_tvalid) begin
                    // Source withdrew before sending anything: release the grant.
                    cancel  = 1'b1;
                    state_d = ST_IDLE;
                end else if (accept) begin
                    started_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            ptr_q     <= CH_W'(NUM_CH - 1);
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            started_q <= started_d;
        end
    end

    always_comb begin
        busy      = (state_q == ST_GRANT);
        grant_idx = grant_q;
        ch_ack    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_ack[i] = busy && (grant_q == CH_W'(i));
        end
    end

`ifdef PCIE_TX_ARBITER_STATS_EN
    logic [NUM_CH*32-1:0] tlp_cnt_q;
    logic [15:0]          cancel_cnt_q;

    always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tlp_cnt_q    <= '0;
            cancel_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (done && grant_q == CH_W'(i)) begin
                    tlp_cnt_q[i*32 +: 32] <= tlp_cnt_q[i*32 +: 32] + 32'd1;
                end
            end
            if (cancel && cancel_cnt_q != '1) begin
                cancel_cnt_q <= cancel_cnt_q + 16'd1;
            end
        end
    end

    assign tlp_cnt    = tlp_cnt_q;
    assign cancel_cnt = cancel_cnt_q;
`endif

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Self-checking bench for pcie_tx_arbiter: a round-robin and a fixed-priority instance
// share stimulus and are each checked every cycle against a behavioural model.
module tb_pcie_tx_arbiter;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int CW = 2;

    logic pcie_clk = 1'b0;
    logic sys_rst_n;
    logic [N-1:0]    ch_req, ch_tvalid, ch_tlast;
    logic [N*KW-1:0] ch_tkeep;
    logic [N*DW-1:0] ch_tdata;
    logic [N*4-1:0]  ch_tuser;
    logic            tx_tready;

    logic [N-1:0] rr_ack, rr_tready, fp_ack, fp_tready;
    logic rr_tvalid, rr_tlast, rr_busy, fp_tvalid, fp_tlast, fp_busy;
    logic [KW-1:0] rr_tkeep, fp_tkeep;
    logic [DW-1:0] rr_tdata, fp_tdata;
    logic [3:0]    rr_tuser, fp_tuser;
    logic [CW-1:0] rr_gidx, fp_gidx;
`ifdef PCIE_TX_ARBITER_STATS_EN
    logic [N*32-1:0] rr_tlp_cnt, fp_tlp_cnt;
    logic [15:0]     rr_cancel_cnt, fp_cancel_cnt;
`endif

    always #5 pcie_clk = ~pcie_clk;

    pcie_tx_arbiter #(.NUM_CH(N), .C_DATA_WIDTH(DW), .ARB_MODE(1)) dut_rr (
        .pcie_clk(pcie_clk), .sys_rst_n(sys_rst_n), .ch_req(ch_req), .ch_ack(rr_ack),
        .ch_tvalid(ch_tvalid), .ch_tready(rr_tready), .ch_tlast(ch_tlast), .ch_tkeep(ch_tkeep),
        .ch_tdata(ch_tdata), .ch_tuser(ch_tuser), .tx_tready(tx_tready), .tx_tvalid(rr_tvalid),
        .tx_tlast(rr_tlast), .tx_tkeep(rr_tkeep), .tx_tdata(rr_tdata), .tx_tuser(rr_tuser),
        .grant_idx(rr_gidx), .busy(rr_busy)
`ifdef PCIE_TX_ARBITER_STATS_EN
        , .tlp_cnt(rr_tlp_cnt), .cancel_cnt(rr_cancel_cnt)
`endif
    );

    pcie_tx_arbiter #(.NUM_CH(N), .C_DATA_WIDTH(DW), .ARB_MODE(0)) dut_fp (
        .pcie_clk(pcie_clk), .sys_rst_n(sys_rst_n), .ch_req(ch_req), .ch_ack(fp_ack),
        .ch_tvalid(ch_tvalid), .ch_tready(fp_tready), .ch_tlast(ch_tlast), .ch_tkeep(ch_tkeep),
        .ch_tdata(ch_tdata), .ch_tuser(ch_tuser), .tx_tready(tx_tready), .tx_tvalid(fp_tvalid),
        .tx_tlast(fp_tlast), .tx_tkeep(fp_tkeep), .tx_tdata(fp_tdata), .tx_tuser(fp_tuser),
        .grant_idx(fp_gidx), .busy(fp_busy)
`ifdef PCIE_TX_ARBITER_STATS_EN
        , .tlp_cnt(fp_tlp_cnt), .cancel_cnt(fp_cancel_cnt)
`endif
    );

    int vectors = 0;
    int errors  = 0;

    // Reference model, index 0 = round-robin instance, 1 = fixed-priority instance.
    int          m_owner[2];
    int          m_last[2];
    int          m_ptr[2];
    bit          m_started[2];
    logic [31:0] m_tlp[2][N];
    int          m_cancel[2];

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = -1; m_last[m] = 0; m_ptr[m] = N - 1; m_started[m] = 0;
            m_cancel[m] = 0;
            for (int i = 0; i < N; i++) m_tlp[m][i] = '0;
        end
    endfunction

    function automatic void model_step();
        for (int m = 0; m < 2; m++) begin
            int o = m_owner[m];
            if (o < 0) begin
                if (ch_req != '0) begin
                    int w = -1;
                    if (m == 1) begin
                        for (int i = 0; i < N; i++) if (w < 0 && ch_req[i]) w = i;
                    end else begin
                        for (int k = 1; k <= N; k++) begin
                            int c = (m_ptr[m] + k) % N;
                            if (w < 0 && ch_req[c]) w = c;
                        end
                        m_ptr[m] = w;
                    end
                    m_owner[m] = w; m_last[m] = w; m_started[m] = 0;
                end
            end else begin
                bit acc = ch_tvalid[o] && tx_tready;
                if (acc && ch_tlast[o]) begin
                    m_owner[m] = -1;
                    m_tlp[m][o] = m_tlp[m][o] + 32'd1;
                end else if (!ch_req[o] && !m_started[m] && !ch_tvalid[o]) begin
                    m_owner[m] = -1;
                    if (m_cancel[m] < 65535) m_cancel[m]++;
                end else if (acc) begin
                    m_started[m] = 1;
                end
            end
        end
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int m = 0; m < 2; m++) begin
            logic [88:0] act, exp;
            logic [3:0] a_ack, a_tr, e_ack, e_tr;
            logic a_busy, a_tv, a_tl, e_busy, e_tv;
            logic [KW-1:0] a_tk;
            logic [DW-1:0] a_td;
            logic [3:0] a_tu;
            logic [CW-1:0] a_gi;
            logic [76:0] e_data;
            int o = m_owner[m];
            if (m == 0) begin
                a_ack = rr_ack; a_tr = rr_tready; a_busy = rr_busy; a_tv = rr_tvalid;
                a_tl = rr_tlast; a_tk = rr_tkeep; a_td = rr_tdata; a_tu = rr_tuser; a_gi = rr_gidx;
            end else begin
                a_ack = fp_ack; a_tr = fp_tready; a_busy = fp_busy; a_tv = fp_tvalid;
                a_tl = fp_tlast; a_tk = fp_tkeep; a_td = fp_tdata; a_tu = fp_tuser; a_gi = fp_gidx;
            end
            act = {a_ack, a_busy, a_tv, a_tr, a_gi, 77'd0};
            e_ack = '0; e_busy = 0; e_tv = 0; e_tr = '0; e_data = '0;
            if (o >= 0) begin
                act[76:0] = {a_tl, a_tk, a_tu, a_td};
                e_ack  = 4'(1 << o);
                e_busy = 1'b1;
                e_tv   = ch_tvalid[o];
                e_tr   = tx_tready ? 4'(1 << o) : 4'd0;
                e_data = {ch_tlast[o], ch_tkeep[o*KW +: KW], ch_tuser[o*4 +: 4], ch_tdata[o*DW +: DW]};
            end
            exp = {e_ack, e_busy, e_tv, e_tr, CW'(m_last[m]), e_data};
            vectors++;
            if (act !== exp) begin
                errors++;
                $display("FAIL %s %s act=%h exp=%h", tag, (m == 0) ? "rr" : "fp", act, exp);
            end
`ifdef PCIE_TX_ARBITER_STATS_EN
            begin
                logic [N*32-1:0] e_cnt, a_cnt;
                logic [15:0] a_can;
                for (int i = 0; i < N; i++) e_cnt[i*32 +: 32] = m_tlp[m][i];
                a_cnt = (m == 0) ? rr_tlp_cnt : fp_tlp_cnt;
                a_can = (m == 0) ? rr_cancel_cnt : fp_cancel_cnt;
                vectors++;
                if (a_cnt !== e_cnt || a_can !== 16'(m_cancel[m])) begin
                    errors++;
                    $display("FAIL %s_stats m=%0d act=%h/%h exp=%h/%h", tag, m, a_cnt, a_can, e_cnt, 16'(m_cancel[m]));
                end
            end
`endif
        end
    endtask

    task automatic cycle(input string tag);
        #1;
        check_all(tag);
        @(posedge pcie_clk);
        if (!sys_rst_n) model_reset(); else model_step();
        #1;
    endtask

    // Source models: each channel sends rem TLPs of len beats, offering beats only while acked.
    int src_rem[N], src_beat[N], src_len[N];
    bit use_fp;
    bit          tv_hist[$];
    logic [15:0] acc_q[$];
    bit          last_q[$];
    int          done_q[$];

    task automatic do_reset();
        sys_rst_n = 1'b0;
        model_reset();
        ch_req = '0; ch_tvalid = '0; ch_tlast = '0; tx_tready = 1'b1;
        for (int i = 0; i < N; i++) begin src_rem[i] = 0; src_beat[i] = 0; src_len[i] = 3; end
        tv_hist.delete(); acc_q.delete(); last_q.delete(); done_q.delete();
        cycle("reset");
        sys_rst_n = 1'b1;
    endtask

    task automatic run_src(input int n, input bit bp, input string tag);
        for (int c = 0; c < n; c++) begin
            logic [N-1:0] ack, tr;
            logic tv, tl;
            logic [DW-1:0] td;
            ack = use_fp ? fp_ack : rr_ack;
            tx_tready = bp ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
            for (int i = 0; i < N; i++) begin
                ch_req[i]    = src_rem[i] > 0;
                ch_tvalid[i] = ack[i] && src_rem[i] > 0;
                ch_tlast[i]  = src_beat[i] == src_len[i] - 1;
                ch_tdata[i*DW +: DW] = {32'hDA7A_0000 | 32'(i), 16'h0, 8'(i), 8'(src_beat[i])};
                ch_tkeep[i*KW +: KW] = ch_tlast[i] ? 8'h0F : 8'hFF;
                ch_tuser[i*4 +: 4]   = 4'(i + 1);
            end
            #1;
            check_all(tag);
            tr = use_fp ? fp_tready : rr_tready;
            tv = use_fp ? fp_tvalid : rr_tvalid;
            tl = use_fp ? fp_tlast : rr_tlast;
            td = use_fp ? fp_tdata : rr_tdata;
            tv_hist.push_back(tv);
            if (tv && tx_tready) begin acc_q.push_back(td[15:0]); last_q.push_back(tl); end
            @(posedge pcie_clk);
            if (!sys_rst_n) model_reset(); else model_step();
            for (int i = 0; i < N; i++) begin
                if (ch_tvalid[i] && tr[i]) begin
                    if (ch_tlast[i]) begin
                        src_beat[i] = 0; src_rem[i]--; done_q.push_back(i);
                    end else begin
                        src_beat[i]++;
                    end
                end
            end
            #1;
        end
    endtask

    typedef struct {
        bit rst; logic [3:0] req, tv, tl; bit tr;
        logic [3:0] e_ack; logic e_tv; logic [3:0] e_tr;
    } vec_t;
    vec_t tbl[15];

    initial begin
        tbl[0]  = '{1, 4'hF, 4'hF, 4'h0, 1, 4'h0, 0, 4'h0};
        tbl[1]  = '{1, 4'hF, 4'hF, 4'h0, 1, 4'h0, 0, 4'h0};
        tbl[2]  = '{0, 4'hF, 4'h0, 4'h0, 1, 4'h0, 0, 4'h0};
        tbl[3]  = '{0, 4'hF, 4'h1, 4'h1, 1, 4'h1, 1, 4'h1};
        tbl[4]  = '{0, 4'hE, 4'h0, 4'h0, 1, 4'h0, 0, 4'h0};
        tbl[5]  = '{0, 4'hE, 4'h2, 4'h0, 0, 4'h2, 1, 4'h0};
        tbl[6]  = '{0, 4'hE, 4'h2, 4'h0, 1, 4'h2, 1, 4'h2};
        tbl[7]  = '{0, 4'hC, 4'h0, 4'h0, 1, 4'h2, 0, 4'h2};
        tbl[8]  = '{0, 4'hC, 4'h2, 4'h2, 1, 4'h2, 1, 4'h2};
        tbl[9]  = '{0, 4'hC, 4'h0, 4'h0, 1, 4'h0, 0, 4'h0};
        tbl[10] = '{0, 4'h8, 4'h0, 4'h0, 1, 4'h4, 0, 4'h4};
        tbl[11] = '{0, 4'h8, 4'h0, 4'h0, 1, 4'h0, 0, 4'h0};
        tbl[12] = '{0, 4'h0, 4'hF, 4'h0, 1, 4'h8, 1, 4'h8};
        tbl[13] = '{0, 4'h0, 4'h8, 4'h8, 1, 4'h8, 1, 4'h8};
        tbl[14] = '{0, 4'h0, 4'hF, 4'hF, 1, 4'h0, 0, 4'h0};

        sys_rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) begin
            ch_tdata[i*DW +: DW] = {32'hC0DE_0000 | 32'(i), 32'(i)};
            ch_tkeep[i*KW +: KW] = 8'hFF;
            ch_tuser[i*4 +: 4]   = 4'(i);
        end

        // Reset behaviour, grant latency, hold-after-start and cancellation.
        for (int v = 0; v < 15; v++) begin
            sys_rst_n = !tbl[v].rst;
            if (tbl[v].rst) model_reset();
            ch_req = tbl[v].req; ch_tvalid = tbl[v].tv; ch_tlast = tbl[v].tl; tx_tready = tbl[v].tr;
            #1;
            cmp($sformatf("tbl%0d", v), {55'd0, rr_ack, rr_tvalid, rr_tready},
                {55'd0, tbl[v].e_ack, tbl[v].e_tv, tbl[v].e_tr});
            cycle($sformatf("tbl%0d_model", v));
        end
`ifdef PCIE_TX_ARBITER_STATS_EN
        cmp("stats_cancel", 64'(rr_cancel_cnt), 64'd1);
        cmp("stats_ch2", 64'(rr_tlp_cnt[2*32 +: 32]), 64'd0);
        cmp("stats_ch0", 64'(rr_tlp_cnt[0 +: 32]), 64'd1);
`endif

        // Round-robin fairness: four saturated 3-beat sources.
        use_fp = 0;
        do_reset();
        for (int i = 0; i < N; i++) src_rem[i] = 1000;
        run_src(48, 0, "rr_fair");
        begin
            logic [47:0] tva, tve;
            tva = '0; tve = '0;
            for (int c = 0; c < 48; c++) begin
                if (c < tv_hist.size()) tva[c] = tv_hist[c];
                tve[c] = (c % 4 != 0);
            end
            cmp("rr_tvalid_pattern", 64'(tva), 64'(tve));
        end
        cmp("rr_tlp_count", 64'(done_q.size()), 64'd12);
        for (int k = 0; k < 36; k++) begin
            logic [15:0] a;
            a = (k < acc_q.size()) ? acc_q[k] : 16'hFFFF;
            cmp($sformatf("rr_beat%0d", k), 64'(a), 64'({8'((k / 3) % 4), 8'(k % 3)}));
        end

        // Fixed priority: ch0/ch1 arrive during a ch3 TLP.
        use_fp = 1;
        do_reset();
        src_rem[3] = 2;
        run_src(2, 0, "fp_a");
        src_rem[0] = 1; src_rem[1] = 1;
        run_src(18, 0, "fp_b");
        begin
            int exp_done[4] = '{3, 0, 1, 3};
            cmp("fp_done_count", 64'(done_q.size()), 64'd4);
            for (int k = 0; k < 4; k++)
                cmp($sformatf("fp_order%0d", k), 64'((k < done_q.size()) ? done_q[k] : -1), 64'(exp_done[k]));
            for (int k = 0; k < 12; k++)
                cmp($sformatf("fp_beat%0d", k), 64'((k < acc_q.size()) ? acc_q[k] : 16'hFFFF),
                    64'({8'(exp_done[k / 3]), 8'(k % 3)}));
        end

        // Backpressure on a 4-beat TLP.
        use_fp = 0;
        do_reset();
        src_rem[2] = 1; src_len[2] = 4;
        run_src(20, 1, "bp");
        cmp("bp_beats", 64'(acc_q.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            cmp($sformatf("bp_data%0d", k), 64'((k < acc_q.size()) ? acc_q[k] : 16'hFFFF), 64'({8'd2, 8'(k)}));
            cmp($sformatf("bp_last%0d", k), 64'((k < last_q.size()) ? last_q[k] : 1'bx), 64'(k == 3));
        end

        // Reset mid-packet after two of five beats.
        do_reset();
        src_rem[1] = 1; src_len[1] = 5;
        run_src(3, 0, "rst_mid");
        cmp("rst_mid_beats", 64'(src_beat[1]), 64'd2);
        sys_rst_n = 1'b0;
        model_reset();
        #1;
        cmp("rst_mid_tvalid", 64'(rr_tvalid), 64'd0);
        src_rem[1] = 0; ch_req = '0; ch_tvalid = '0;
        cycle("rst_mid_hold");
        sys_rst_n = 1'b1;
        #1;
        cmp("rst_mid_idle", 64'({rr_busy, rr_ack, rr_tvalid}), 64'd0);
        cycle("rst_mid_after");

        // Randomized traffic with occasional asynchronous reset.
        for (int c = 0; c < 3000; c++) begin
            sys_rst_n = 1'b1;
            ch_req    = 4'($urandom);
            ch_tvalid = 4'($urandom);
            ch_tlast  = 4'($urandom & $urandom);
            tx_tready = ($urandom_range(0, 3) != 0);
            for (int w = 0; w < N * DW / 32; w++) ch_tdata[w*32 +: 32] = $urandom;
            ch_tkeep = $urandom;
            ch_tuser = 16'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                #2;
                sys_rst_n = 1'b0;
                model_reset();
            end
            cycle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
